// File: rtl/mdu_unit_if.sv
// Handshake/data bundle between the E stage and the multiply/divide unit.
interface mdu_unit_if;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] rd_data;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, mdu_op, a, b,
      input  busy, rd_data, hi, lo
   );

   modport slave (
      input  start, mdu_op, a, b,
      output busy, rd_data, hi, lo
   );
endinterface

// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO registers. The result is computed in one
// shot when the op launches; the busy window is purely counter-modelled.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no op in flight; mthi/mtlo accepted, start with op 1-4 launches
// S_RUN  | op in flight; counter counts down, commit to HI/LO at count 1
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic      clk,
   input logic      reset,
   mdu_unit_if.slave bus
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state;
   logic [CNT_W-1:0]   counter;
   logic [31:0]        hi_q, lo_q;
   logic [31:0]        hi_tmp, lo_tmp;
   logic               commit_en;
   logic               busy_q;

   logic               is_mdu_op;
   logic               is_mult;
   logic [63:0]        prod_s, prod_u;
   logic signed [31:0] sa, sb, sq, sr;
   logic [31:0]        uq, ur;
   logic               div_zero;
   logic [31:0]        res_hi, res_lo;
   logic               res_valid;
   logic [31:0]        rd_mux;

   // One-shot arithmetic on the current operands; only sampled at launch.
   always_comb begin
      is_mdu_op = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU) ||
                  (bus.mdu_op == OP_DIV)  || (bus.mdu_op == OP_DIVU);
      is_mult   = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU);
      prod_s    = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
      prod_u    = {32'b0, bus.a} * {32'b0, bus.b};
      sa        = $signed(bus.a);
      sb        = $signed(bus.b);
      div_zero  = (bus.b == 32'd0);
      sq        = '0;
      sr        = '0;
      uq        = '0;
      ur        = '0;
      if (!div_zero) begin
         uq = bus.a / bus.b;
         ur = bus.a % bus.b;
         // The one signed quotient that does not fit: wrap it explicitly.
         if (bus.a == 32'h8000_0000 && bus.b == 32'hFFFF_FFFF) begin
            sq = $signed(32'h8000_0000);
            sr = '0;
         end else begin
            sq = sa / sb;
            sr = sa % sb;
         end
      end
      res_hi    = '0;
      res_lo    = '0;
      res_valid = 1'b0;
      case (bus.mdu_op)
         OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_valid = 1'b1; end
         OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_valid = 1'b1; end
         OP_DIV:   begin res_hi = sr; res_lo = sq; res_valid = !div_zero; end
         OP_DIVU:  begin res_hi = ur; res_lo = uq; res_valid = !div_zero; end
         default:  begin res_hi = '0; res_lo = '0; res_valid = 1'b0; end
      endcase
   end

   // mfhi/mflo read port; returns architectural HI/LO even while running.
   always_comb begin
      rd_mux = '0;
      case (bus.mdu_op)
         OP_MFHI: rd_mux = hi_q;
         OP_MFLO: rd_mux = lo_q;
         default: rd_mux = '0;
      endcase
   end

   // Launch/countdown/commit state machine; reset aborts without commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         counter   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         hi_tmp    <= '0;
         lo_tmp    <= '0;
         commit_en <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start && is_mdu_op) begin
                  state     <= S_RUN;
                  busy_q    <= 1'b1;
                  hi_tmp    <= res_hi;
                  lo_tmp    <= res_lo;
                  commit_en <= res_valid;
                  counter   <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               end else if (bus.mdu_op == OP_MTHI) begin
                  hi_q <= bus.a;
               end else if (bus.mdu_op == OP_MTLO) begin
                  lo_q <= bus.a;
               end
            end
            S_RUN: begin
               if (counter == CNT_W'(1)) begin
                  if (commit_en) begin
                     hi_q <= hi_tmp;
                     lo_q <= lo_tmp;
                  end
                  commit_en <= 1'b0;
                  counter   <= '0;
                  busy_q    <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  counter <= counter - CNT_W'(1);
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.rd_data = rd_mux;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed ops push cycle-stamped expectations into a
// scoreboard; a negedge monitor pops and compares them as cycles go by.
module tb_mdu_unit;

   localparam int KB = 0;  // busy
   localparam int KH = 1;  // hi
   localparam int KL = 2;  // lo
   localparam int KR = 3;  // rd_data

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mdu_unit_if bus ();

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Insert keeping the queue ordered by cycle (stable for equal cycles).
   task automatic expect_at(input int c, input int kind, input logic [31:0] v, input string nm);
      exp_t e;
      int   i;
      e.cyc  = c;
      e.kind = kind;
      e.val  = v;
      e.name = nm;
      i = 0;
      while (i < sb_q.size() && sb_q[i].cyc <= c) i++;
      sb_q.insert(i, e);
   endtask

   exp_t        mon_e;
   logic [31:0] mon_act;

   // Monitor: compare every expectation stamped for the current cycle.
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         mon_e = sb_q.pop_front();
         case (mon_e.kind)
            KB:      mon_act = {31'b0, bus.busy};
            KH:      mon_act = bus.hi;
            KL:      mon_act = bus.lo;
            default: mon_act = bus.rd_data;
         endcase
         n_cmp++;
         if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
            n_bad++;
            $display("FAIL %s (kind %0d) at cycle %0d (due %0d): got %h required %h",
                     mon_e.name, mon_e.kind, cyc, mon_e.cyc, mon_act, mon_e.val);
         end
      end
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic st, output int t);
      @(posedge clk);
      #1;
      bus.start  = st;
      bus.mdu_op = op;
      bus.a      = av;
      bus.b      = bv;
      t = cyc;
   endtask

   task automatic busy_window(input int t, input int n, input string nm);
      for (int k = 1; k <= n; k++) expect_at(t + k, KB, 32'd1, {nm, "_busy"});
      expect_at(t + n + 1, KB, 32'd0, {nm, "_busy_drop"});
   endtask

   // Launch one op, check busy window, pre/post commit HI/LO, then mfhi/mflo.
   task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input int n, input logic [31:0] old_hi, input logic [31:0] old_lo,
                         input logic [31:0] new_hi, input logic [31:0] new_lo, input string nm);
      int t, d;
      drive(op, av, bv, 1'b1, t);
      busy_window(t, n, nm);
      expect_at(t + n,     KH, old_hi, {nm, "_hi_before"});
      expect_at(t + n,     KL, old_lo, {nm, "_lo_before"});
      expect_at(t + n + 1, KH, new_hi, {nm, "_hi"});
      expect_at(t + n + 1, KL, new_lo, {nm, "_lo"});
      repeat (n) drive(4'd0, 32'd0, 32'd0, 1'b0, d);
      drive(4'd5, 32'd0, 32'd0, 1'b0, d);
      expect_at(d, KR, new_hi, {nm, "_mfhi"});
      drive(4'd6, 32'd0, 32'd0, 1'b0, d);
      expect_at(d, KR, new_lo, {nm, "_mflo"});
   endtask

   initial begin
      int t, d;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.mdu_op = 4'd0;
      bus.a      = '0;
      bus.b      = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      t = cyc;
      expect_at(t, KB, 32'd0, "rst_busy");
      expect_at(t, KH, 32'd0, "rst_hi");
      expect_at(t, KL, 32'd0, "rst_lo");
      expect_at(t, KR, 32'd0, "rst_rd");

      run_op(4'd1, 32'hFFFF_FFFE, 32'd3,        5,  32'h0,         32'h0,
             32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
      run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
             32'hFFFF_FFFE, 32'h0000_0001, "multu");
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFE, 32'h0000_0001,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
      run_op(4'd4, 32'd7,         32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
             32'd1,         32'd3,         "divu");

      drive(4'd7, 32'h0000_1234, 32'd0, 1'b0, t);
      expect_at(t + 1, KH, 32'h0000_1234, "mthi_1234");
      expect_at(t + 1, KB, 32'd0,         "mthi_nobusy");

      run_op(4'd3, 32'd55,        32'd0,         10, 32'h0000_1234, 32'd3,
             32'h0000_1234, 32'd3,         "div0");
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_1234, 32'd3,
             32'd0,         32'h8000_0000, "divovf");
      run_op(4'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'd0,         32'h8000_0000,
             32'd1,         32'hFFFF_FFFD, "divneg");

      // mthi then mtlo in IDLE, read both back; busy stays low.
      drive(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0, t);
      expect_at(t + 1, KH, 32'hDEAD_BEEF, "mthi_q");
      for (int k = 1; k <= 3; k++) expect_at(t + k, KB, 32'd0, "mtx_nobusy");
      drive(4'd8, 32'h1234_5678, 32'd0, 1'b0, d);
      drive(4'd5, 32'd0, 32'd0, 1'b0, d);
      expect_at(d, KR, 32'hDEAD_BEEF, "mfhi_after_mthi");
      drive(4'd6, 32'd0, 32'd0, 1'b0, d);
      expect_at(d, KR, 32'h1234_5678, "mflo_after_mtlo");

      // Op without start, and start with an out-of-range op: no launch.
      drive(4'd1, 32'd5, 32'd7, 1'b0, t);
      expect_at(t + 1, KB, 32'd0, "op_nostart");
      expect_at(t + 1, KH, 32'hDEAD_BEEF, "op_nostart_hi");
      drive(4'd9, 32'd5, 32'd7, 1'b1, t);
      expect_at(t + 1, KB, 32'd0, "start_badop");
      expect_at(t + 1, KL, 32'h1234_5678, "start_badop_lo");

      // Mult in flight; a second start, mthi and mtlo during RUN are ignored.
      drive(4'd1, 32'd5, 32'd7, 1'b1, t);
      busy_window(t, 5, "ign");
      expect_at(t + 5, KH, 32'hDEAD_BEEF, "ign_hi_before");
      expect_at(t + 5, KL, 32'h1234_5678, "ign_lo_before");
      expect_at(t + 6, KH, 32'd0,         "ign_hi");
      expect_at(t + 6, KL, 32'd35,        "ign_lo");
      expect_at(t + 7, KB, 32'd0,         "ign_no_relaunch");
      expect_at(t + 7, KH, 32'd0,         "ign_hi_stable");
      drive(4'd4, 32'd100, 32'd3, 1'b1, d);
      drive(4'd7, 32'h0000_AAAA, 32'd0, 1'b0, d);
      drive(4'd8, 32'h0000_BBBB, 32'd0, 1'b0, d);
      drive(4'd5, 32'd0, 32'd0, 1'b0, d);
      expect_at(d, KR, 32'hDEAD_BEEF, "ign_mfhi_old");
      repeat (3) drive(4'd0, 32'd0, 32'd0, 1'b0, d);

      // Reset during a div: aborts, and nothing commits later.
      drive(4'd3, 32'd100, 32'd7, 1'b1, t);
      expect_at(t + 4, KB, 32'd1, "rstrun_busy");
      expect_at(t + 5, KB, 32'd0, "rstrun_busy_clr");
      expect_at(t + 5, KH, 32'd0, "rstrun_hi");
      expect_at(t + 5, KL, 32'd0, "rstrun_lo");
      expect_at(t + 10, KH, 32'd0, "rstrun_no_commit_hi");
      expect_at(t + 11, KL, 32'd0, "rstrun_no_commit_lo");
      expect_at(t + 11, KB, 32'd0, "rstrun_idle");
      repeat (3) drive(4'd0, 32'd0, 32'd0, 1'b0, d);
      drive(4'd0, 32'd0, 32'd0, 1'b0, d);
      reset = 1'b1;
      drive(4'd0, 32'd0, 32'd0, 1'b0, d);
      reset = 1'b0;
      repeat (8) drive(4'd0, 32'd0, 32'd0, 1'b0, d);

      repeat (2) @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d unchecked entries required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
